// File: rtl/bus_host_arb.sv
// Round-robin arbiter sharing one device port among several bus hosts.
// One transaction is outstanding at a time. The response is routed back to
// the owning host, or an error response is generated after a wait timeout.
module bus_host_arb #(
  parameter int unsigned NrHosts       = 3,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NrHosts-1:0]                     host_req_i,
  output logic [NrHosts-1:0]                     host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                     host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                     host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o,
  output logic [NrHosts-1:0]                     host_err_o,
  output logic                                   dev_req_o,
  output logic [AddressWidth-1:0]                dev_addr_o,
  output logic                                   dev_we_o,
  output logic [DataWidth/8-1:0]                 dev_be_o,
  output logic [DataWidth-1:0]                   dev_wdata_o,
  input  logic                                   dev_rvalid_i,
  input  logic [DataWidth-1:0]                   dev_rdata_i,
  input  logic                                   dev_err_i,
  output logic                                   timeout_o,
  output logic                                   stray_rsp_o
);

  localparam int unsigned IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  typedef enum logic {StIdle, StWait} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              stray_q, stray_d;

  logic              eligible;
  logic              found;
  logic [IdxW-1:0]   winner;
  logic [IdxW-1:0]   cand;

  // State register with synchronous reset; host 0 wins first after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ptr_q   <= IdxW'(NrHosts - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      stray_q <= stray_d;
    end
  end

  // Arbitration, device request muxing, response routing and next state.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    stray_d       = stray_q;
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_rdata_o  = '0;
    host_err_o    = '0;
    dev_req_o     = 1'b0;
    dev_addr_o    = '0;
    dev_we_o      = 1'b0;
    dev_be_o      = '0;
    dev_wdata_o   = '0;
    timeout_o     = 1'b0;
    found         = 1'b0;
    winner        = '0;
    cand          = '0;

    // A response arriving in WAIT frees the port in the same cycle.
    eligible = !rst_i && ((state_q == StIdle) ||
                          ((state_q == StWait) && dev_rvalid_i));

    // Search ptr+1, ptr+2, ... modulo NrHosts; first requester wins.
    for (int unsigned i = 1; i <= NrHosts; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % NrHosts);
      if (eligible && !found && host_req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end

    if (found) begin
      host_gnt_o[winner] = 1'b1;
      dev_req_o          = 1'b1;
      dev_addr_o         = host_addr_i[winner];
      dev_we_o           = host_we_i[winner];
      dev_be_o           = host_be_i[winner];
      dev_wdata_o        = host_wdata_i[winner];
      state_d            = StWait;
      ptr_d              = winner;
      owner_d            = winner;
      cnt_d              = '0;
    end

    if (!rst_i && (state_q == StWait)) begin
      if (dev_rvalid_i) begin
        host_rvalid_o[owner_q] = 1'b1;
        host_rdata_o[owner_q]  = dev_rdata_i;
        host_err_o[owner_q]    = dev_err_i;
        if (!found) state_d = StIdle;
      end else if (cnt_q == CntW'(TimeoutCycles)) begin
        host_rvalid_o[owner_q] = 1'b1;
        host_err_o[owner_q]    = 1'b1;
        timeout_o              = 1'b1;
        state_d                = StIdle;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    if (!rst_i && (state_q == StIdle) && dev_rvalid_i) stray_d = 1'b1;
  end

  assign stray_rsp_o = stray_q;

endmodule

// File: tb/tb_bus_host_arb.sv
module tb_bus_host_arb;
  localparam int NH = 3;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [2:0]           req;
  logic [2:0]           gnt;
  logic [2:0][31:0]     addr;
  logic [2:0]           we;
  logic [2:0][3:0]      be;
  logic [2:0][31:0]     wdata;
  logic [2:0]           rvalid;
  logic [2:0][31:0]     rdata;
  logic [2:0]           herr;
  logic                 dreq;
  logic [31:0]          daddr;
  logic                 dwe;
  logic [3:0]           dbe;
  logic [31:0]          dwdata;
  logic                 dv;
  logic [31:0]          drdata;
  logic                 derr;
  logic                 tmo;
  logic                 stray;

  bus_host_arb #(.NrHosts(NH), .AddressWidth(32), .DataWidth(32), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(req), .host_gnt_o(gnt),
    .host_addr_i(addr), .host_we_i(we), .host_be_i(be), .host_wdata_i(wdata),
    .host_rvalid_o(rvalid), .host_rdata_o(rdata), .host_err_o(herr),
    .dev_req_o(dreq), .dev_addr_o(daddr), .dev_we_o(dwe), .dev_be_o(dbe), .dev_wdata_o(dwdata),
    .dev_rvalid_i(dv), .dev_rdata_i(drdata), .dev_err_i(derr),
    .timeout_o(tmo), .stray_rsp_o(stray)
  );

  int errors = 0;
  int checks = 0;

  // Transaction-level reference: is something outstanding, who owns it,
  // how long it has waited, who was served last, and the stray flag.
  bit pend   = 0;
  int owner  = 0;
  int last   = NH - 1;
  int age    = 0;
  bit mstray = 0;
  int m_w;
  bit m_resp, m_to;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, then compare all outputs against the reference.
  task automatic drive(input logic r, input logic [2:0] rq, input logic d,
                       input logic [31:0] rd, input logic de);
    logic [2:0]       e_gnt, e_rv, e_err;
    logic [2:0][31:0] e_rdata;
    logic             e_to, e_dreq, e_dwe;
    logic [31:0]      e_daddr, e_dwdata;
    logic [3:0]       e_dbe;
    rst = r; req = rq; dv = d; drdata = rd; derr = de;
    #3;
    e_gnt = '0; e_rv = '0; e_err = '0; e_rdata = '0; e_to = 0;
    e_dreq = 0; e_dwe = 0; e_daddr = '0; e_dwdata = '0; e_dbe = '0;
    m_w = -1; m_resp = 0; m_to = 0;
    if (!r) begin
      m_resp = pend && d;
      m_to   = pend && !d && (age == TO);
      if (!pend || m_resp)
        for (int k = 1; k <= NH; k++) begin
          int h;
          h = (last + k) % NH;
          if (m_w < 0 && rq[h]) m_w = h;
        end
      if (m_w >= 0) begin
        e_gnt[m_w] = 1'b1; e_dreq = 1'b1;
        e_daddr = addr[m_w]; e_dwe = we[m_w]; e_dbe = be[m_w]; e_dwdata = wdata[m_w];
      end
      if (m_resp) begin
        e_rv[owner] = 1'b1; e_rdata[owner] = rd; e_err[owner] = de;
      end
      if (m_to) begin
        e_rv[owner] = 1'b1; e_err[owner] = 1'b1; e_to = 1'b1;
      end
    end
    chk("gnt", gnt, e_gnt);
    chk("dev_req", dreq, e_dreq);
    chk("dev_addr", daddr, e_daddr);
    chk("dev_we", dwe, e_dwe);
    chk("dev_be", dbe, e_dbe);
    chk("dev_wdata", dwdata, e_dwdata);
    chk("rvalid", rvalid, e_rv);
    chk("rdata", rdata, e_rdata);
    chk("host_err", herr, e_err);
    chk("timeout", tmo, e_to);
    chk("stray", stray, mstray);
  endtask

  // Advance one clock and update the reference with this cycle's outcome.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      pend = 0; owner = 0; last = NH - 1; age = 0; mstray = 0;
    end else begin
      if (!pend && dv) mstray = 1;
      if (m_w >= 0) begin
        pend = 1; owner = m_w; age = 0; last = m_w;
      end else if (m_resp || m_to) begin
        pend = 0;
      end else if (pend) begin
        age++;
      end
    end
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic        dv;
    logic [31:0] rd;
    logic [2:0]  gnt;
    logic [2:0]  rv;
    logic        to;
    logic        stray;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // rst, req, dv, rdata, exp gnt, exp rvalid, exp timeout, exp stray
    tbl[0]  = '{1'b1, 3'b111, 1'b0, 32'h0,  3'b000, 3'b000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 3'b111, 1'b0, 32'h0,  3'b001, 3'b000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 3'b111, 1'b1, 32'hA0, 3'b010, 3'b001, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 3'b111, 1'b1, 32'hA1, 3'b100, 3'b010, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 3'b111, 1'b1, 32'hA2, 3'b001, 3'b100, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 3'b000, 1'b1, 32'hA3, 3'b000, 3'b001, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 3'b100, 1'b0, 32'h0,  3'b100, 3'b000, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 3'b100, 1'b1, 32'hB0, 3'b100, 3'b100, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 3'b100, 1'b1, 32'hB1, 3'b100, 3'b100, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 3'b000, 1'b1, 32'hB2, 3'b000, 3'b100, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 3'b000, 1'b1, 32'hC0, 3'b000, 3'b000, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 3'b000, 1'b0, 32'h0,  3'b000, 3'b000, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 3'b000, 1'b0, 32'h0,  3'b000, 3'b000, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 3'b000, 1'b0, 32'h0,  3'b000, 3'b000, 1'b0, 1'b0};

    for (int h = 0; h < NH; h++) begin
      addr[h] = 32'h1000 + 32'(h); we[h] = 1'(h); be[h] = 4'hF; wdata[h] = 32'h5500 + 32'(h);
    end
    rst = 1; req = '0; dv = 0; drdata = '0; derr = 0;
    repeat (2) @(posedge clk);
    #1;

    // Round-robin under full load, single requester, stray response, reset.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].dv, tbl[i].rd, 1'b0);
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_rvalid", i), rvalid, tbl[i].rv);
      chk($sformatf("tbl%0d_timeout", i), tmo, tbl[i].to);
      chk($sformatf("tbl%0d_stray", i), stray, tbl[i].stray);
      if (tbl[i].rv != 3'b000)
        for (int h = 0; h < NH; h++)
          if (tbl[i].rv[h]) chk($sformatf("tbl%0d_rdata", i), rdata[h], tbl[i].rd);
      tick();
    end

    // Host 1 read at 0x100 returning data with an error flag.
    addr[1] = 32'h100; we[1] = 1'b0;
    drive(1, 3'b000, 0, 0, 0); tick();
    drive(0, 3'b010, 0, 0, 0);
    chk("h1_gnt", gnt, 3'b010);
    chk("h1_addr", daddr, 32'h100);
    tick();
    drive(0, 3'b000, 1, 32'hDEADBEEF, 1);
    chk("h1_rvalid", rvalid, 3'b010);
    chk("h1_rdata", rdata[1], 32'hDEADBEEF);
    chk("h1_err", herr, 3'b010);
    chk("h1_others_rdata", {rdata[2], rdata[0]}, 64'h0);
    tick();

    // Timeout: TO silent wait cycles, then an error response with no grant.
    drive(0, 3'b001, 0, 0, 0);
    chk("to_gnt", gnt, 3'b001);
    tick();
    for (int c = 0; c < TO; c++) begin
      drive(0, 3'b000, 0, 0, 0);
      chk($sformatf("to_wait%0d_rvalid", c), rvalid, 3'b000);
      chk($sformatf("to_wait%0d_timeout", c), tmo, 1'b0);
      tick();
    end
    drive(0, 3'b001, 0, 32'hFFFF_FFFF, 0);
    chk("to_rvalid", rvalid, 3'b001);
    chk("to_err", herr, 3'b001);
    chk("to_rdata", rdata[0], 32'h0);
    chk("to_pulse", tmo, 1'b1);
    chk("to_nogrant", gnt, 3'b000);
    tick();
    drive(0, 3'b001, 0, 0, 0);
    chk("to_pulse_end", tmo, 1'b0);
    chk("to_regrant", gnt, 3'b001);
    tick();
    drive(0, 3'b000, 1, 32'h1, 0); tick();

    // Reset while host 0 waits: its response is dropped and counted as stray.
    drive(1, 3'b000, 0, 0, 0); tick();
    drive(0, 3'b111, 0, 0, 0);
    chk("rw_gnt0", gnt, 3'b001);
    tick();
    drive(1, 3'b000, 0, 0, 0);
    chk("rw_rst_rvalid", rvalid, 3'b000);
    chk("rw_rst_gnt", gnt, 3'b000);
    tick();
    drive(0, 3'b000, 1, 32'h77, 0);
    chk("rw_no_resp", rvalid, 3'b000);
    tick();
    drive(0, 3'b111, 0, 0, 0);
    chk("rw_stray", stray, 1'b1);
    chk("rw_gnt_from0", gnt, 3'b001);
    tick();

    // Randomized traffic against the reference.
    for (int n = 0; n < 400; n++) begin
      for (int h = 0; h < NH; h++) begin
        addr[h] = $urandom; we[h] = 1'($urandom); be[h] = 4'($urandom); wdata[h] = $urandom;
      end
      drive(($urandom_range(0, 49) == 0), 3'($urandom), 1'($urandom_range(0, 1)),
            $urandom, 1'($urandom));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
